// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_pkg
// Description : Shared widths and index type for the 8x3 priority encoder.
//               IN_W  - request vector width
//               OUT_W - encoded index width
//               idx_t - encoded index type, with a cast helper from a loop index
// Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    typedef logic [OUT_W-1:0] idx_t;

    // Converts a request bit position into the encoded index type.
    function automatic idx_t to_idx(input int unsigned pos);
        return idx_t'(pos);
    endfunction

endpackage : prio_enc_pkg
`default_nettype wire

// File: rtl/prio_enc_comb.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_comb
// Description : Purely combinational priority encoder.
//   Parameters : LSB_FIRST - 0: bit 7 has highest priority, 1: bit 0 has
//                highest priority
//   Ports      : in  [7:0] - request vector
//                idx [2:0] - index of the winning request (0 when in == 0)
//                any       - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter int LSB_FIRST = 0
) (
    input  logic [IN_W-1:0] in,
    output idx_t            idx,
    output logic            any
);

    assign any = |in;

    // The scan runs from lowest to highest priority so the last set bit
    // visited is the winner; lower-priority bits are always overwritten.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            always_comb begin
                idx = '0;
                for (int i = IN_W - 1; i >= 0; i--) begin
                    if (in[i]) begin
                        idx = to_idx(i);
                    end
                end
            end
        end else begin : g_msb_first
            always_comb begin
                idx = '0;
                for (int i = 0; i < IN_W; i++) begin
                    if (in[i]) begin
                        idx = to_idx(i);
                    end
                end
            end
        end
    endgenerate

endmodule : prio_enc_comb
`default_nettype wire

// File: rtl/eightxthree_priority_encoder_block.sv
`default_nettype none
// ============================================================================
// Module      : eightxthree_priority_encoder_block
// Description : Registered 8-to-3 priority encoder with capture enable.
//   Parameters : LSB_FIRST - 0: in[7] highest priority, 1: in[0] highest
//   Ports      : clk          - clock, rising edge
//                rst_n        - synchronous active-low reset
//                en           - capture enable
//                in     [7:0] - request vector
//                out    [2:0] - registered winning index
//                valid        - registered "any request was set"
//                onehot [7:0] - registered one-hot of out (only when the
//                               PRIO_ENC_ONEHOT_EN macro is defined)
//   Macros     : PRIO_ENC_ONEHOT_EN - adds the onehot output
// Revision    : 1.0 - initial release
// ============================================================================
module eightxthree_priority_encoder_block
    import prio_enc_pkg::*;
#(
    parameter int LSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [IN_W-1:0] in,
    output idx_t            out,
    output logic            valid
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    output logic [IN_W-1:0] onehot
`endif
);

    idx_t w_idx;
    logic w_any;
    idx_t r_out;
    logic r_valid;

    prio_enc_comb #(
        .LSB_FIRST (LSB_FIRST)
    ) u_comb (
        .in  (in),
        .idx (w_idx),
        .any (w_any)
    );

    // Reset takes precedence over enable; the value presented on the reset
    // edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

`ifdef PRIO_ENC_ONEHOT_EN
    localparam logic [IN_W-1:0] C_ONE = {{(IN_W-1){1'b0}}, 1'b1};

    logic [IN_W-1:0] w_onehot;
    logic [IN_W-1:0] r_onehot;

    // An empty request vector must give all zeros, not bit 0.
    assign w_onehot = w_any ? (C_ONE << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_onehot <= '0;
        end else if (en) begin
            r_onehot <= w_onehot;
        end
    end

    assign onehot = r_onehot;
`endif

endmodule : eightxthree_priority_encoder_block
`default_nettype wire

// File: tb/tb_eightxthree_priority_encoder_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_eightxthree_priority_encoder_block
// Description : Self-checking bench. Two instances (LSB_FIRST = 0 and 1)
//               share one stimulus; each scenario task checks both.
//               Onehot checks are enabled with PRIO_ENC_ONEHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eightxthree_priority_encoder_block;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in;
    logic [2:0] out0, out1;
    logic       valid0, valid1;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [7:0] onehot0, onehot1;
`endif

    int checks = 0;
    int errors = 0;

    eightxthree_priority_encoder_block #(.LSB_FIRST(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in),
        .out    (out0),
        .valid  (valid0)
`ifdef PRIO_ENC_ONEHOT_EN
        ,
        .onehot (onehot0)
`endif
    );

    eightxthree_priority_encoder_block #(.LSB_FIRST(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in),
        .out    (out1),
        .valid  (valid1)
`ifdef PRIO_ENC_ONEHOT_EN
        ,
        .onehot (onehot1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference models: search from the highest-priority end downward.
    function automatic logic [2:0] ref_msb(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [2:0] ref_lsb(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({out0, valid0} !== {3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_msb edge%0d: got out=%0d valid=%b, want out=0 valid=0", k, out0, valid0);
            end
            checks++;
            if ({out1, valid1} !== {3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_lsb edge%0d: got out=%0d valid=%b, want out=0 valid=0", k, out1, valid1);
            end
`ifdef PRIO_ENC_ONEHOT_EN
            checks++;
            if ({onehot0, onehot1} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_onehot edge%0d: got %h/%h, want 00/00", k, onehot0, onehot1);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_bits();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = 8'h01 << i;
            tick();
            checks++;
            if ({out0, valid0} !== {3'(i), 1'b1}) begin
                errors++;
                $display("FAIL walk_msb in=%h: got out=%0d valid=%b, want out=%0d valid=1", in, out0, valid0, i);
            end
            checks++;
            if ({out1, valid1} !== {3'(i), 1'b1}) begin
                errors++;
                $display("FAIL walk_lsb in=%h: got out=%0d valid=%b, want out=%0d valid=1", in, out1, valid1, i);
            end
`ifdef PRIO_ENC_ONEHOT_EN
            checks++;
            if (onehot0 !== in || onehot1 !== in) begin
                errors++;
                $display("FAIL walk_onehot in=%h: got %h/%h, want %h/%h", in, onehot0, onehot1, in, in);
            end
`endif
        end
    endtask

    task automatic test_multi_bit();
        logic [7:0] vecs [2]  = '{8'b0010_0100, 8'hFF};
        logic [2:0] e_msb [2] = '{3'd5, 3'd7};
        logic [2:0] e_lsb [2] = '{3'd2, 3'd0};
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in = vecs[k];
            tick();
            checks++;
            if ({out0, valid0} !== {e_msb[k], 1'b1}) begin
                errors++;
                $display("FAIL multi_msb in=%h: got out=%0d valid=%b, want out=%0d valid=1", in, out0, valid0, e_msb[k]);
            end
            checks++;
            if ({out1, valid1} !== {e_lsb[k], 1'b1}) begin
                errors++;
                $display("FAIL multi_lsb in=%h: got out=%0d valid=%b, want out=%0d valid=1", in, out1, valid1, e_lsb[k]);
            end
        end
    endtask

    task automatic test_zero();
        en = 1'b1;
        in = 8'h00;
        tick();
        checks++;
        if ({out0, valid0, out1, valid1} !== 8'b000_0_000_0) begin
            errors++;
            $display("FAIL zero_in: got %0d/%b %0d/%b, want 0/0 0/0", out0, valid0, out1, valid1);
        end
`ifdef PRIO_ENC_ONEHOT_EN
        checks++;
        if ({onehot0, onehot1} !== 16'h0000) begin
            errors++;
            $display("FAIL zero_onehot: got %h/%h, want 00/00", onehot0, onehot1);
        end
`endif
        in = 8'h01;
        tick();
        checks++;
        if ({out0, valid0, out1, valid1} !== 8'b000_1_000_1) begin
            errors++;
            $display("FAIL zero_then_bit0: got %0d/%b %0d/%b, want 0/1 0/1", out0, valid0, out1, valid1);
        end
    endtask

    task automatic test_enable_hold();
        en = 1'b1;
        in = 8'h40;
        tick();
        checks++;
        if ({out0, valid0, out1, valid1} !== 8'b110_1_110_1) begin
            errors++;
            $display("FAIL hold_capture: got %0d/%b %0d/%b, want 6/1 6/1", out0, valid0, out1, valid1);
        end
        en = 1'b0;
        in = 8'h03;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out0, valid0, out1, valid1} !== 8'b110_1_110_1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %0d/%b %0d/%b, want 6/1 6/1", k, out0, valid0, out1, valid1);
            end
`ifdef PRIO_ENC_ONEHOT_EN
            checks++;
            if ({onehot0, onehot1} !== 16'h4040) begin
                errors++;
                $display("FAIL hold_onehot%0d: got %h/%h, want 40/40", k, onehot0, onehot1);
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        en = 1'b1;
        in = 8'h80;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({out0, valid0, out1, valid1} !== 8'b000_0_000_0) begin
            errors++;
            $display("FAIL mid_reset: got %0d/%b %0d/%b, want 0/0 0/0", out0, valid0, out1, valid1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out0, valid0, out1, valid1} !== 8'b111_1_111_1) begin
            errors++;
            $display("FAIL post_reset: got %0d/%b %0d/%b, want 7/1 7/1", out0, valid0, out1, valid1);
        end
    endtask

    // Back-to-back random captures: a new result every cycle.
    task automatic test_random();
        logic [7:0] v;
        en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            v  = 8'($urandom_range(0, 255));
            in = v;
            tick();
            checks++;
            if ({out0, valid0} !== {ref_msb(v), |v}) begin
                errors++;
                $display("FAIL rand_msb in=%h: got out=%0d valid=%b, want out=%0d valid=%b", v, out0, valid0, ref_msb(v), |v);
            end
            checks++;
            if ({out1, valid1} !== {ref_lsb(v), |v}) begin
                errors++;
                $display("FAIL rand_lsb in=%h: got out=%0d valid=%b, want out=%0d valid=%b", v, out1, valid1, ref_lsb(v), |v);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] v;
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v  = 8'(i);
            in = v;
            tick();
            checks++;
            if ({out0, valid0} !== {ref_msb(v), |v}) begin
                errors++;
                $display("FAIL sweep_msb in=%h: got out=%0d valid=%b, want out=%0d valid=%b", v, out0, valid0, ref_msb(v), |v);
            end
            checks++;
            if ({out1, valid1} !== {ref_lsb(v), |v}) begin
                errors++;
                $display("FAIL sweep_lsb in=%h: got out=%0d valid=%b, want out=%0d valid=%b", v, out1, valid1, ref_lsb(v), |v);
            end
`ifdef PRIO_ENC_ONEHOT_EN
            checks++;
            if (onehot0 !== ((|v) ? (8'h01 << ref_msb(v)) : 8'h00) ||
                onehot1 !== ((|v) ? (8'h01 << ref_lsb(v)) : 8'h00)) begin
                errors++;
                $display("FAIL sweep_onehot in=%h: got %h/%h", v, onehot0, onehot1);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        in    = 8'h00;
        test_reset();
        test_single_bits();
        test_multi_bit();
        test_zero();
        test_enable_hold();
        test_midstream_reset();
        test_random();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_eightxthree_priority_encoder_block
`default_nettype wire
